frontend_req_arbiter: RTL
=========================

Name: frontend_req_arbiter

Overview:
- Shares the single frontend command port of the command scheduler between NUM_REQ requesters (weight loader, activation loader, output writer).
- Uses round-robin arbitration with one output holding register, so the downstream valid/ba_cmd_pm handshake stays stable.
- Records the requester ID of every issued read in an in-order tag FIFO and routes returning read_data back to the correct requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- CMD_W, `FRONTEND_CMD_BITS, width of one frontend_command_t.
- DATA_W, `DQ_BITS*8, write/read data width.
- RD_FIFO_DEPTH, 16, maximum reads outstanding (power of two).
- MAX_HIT_STREAK, 4, row-hit starvation cap (used only with the optional feature).

Ports:
- clk  in  1  clock
- power_on_rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_cmd  in  NUM_REQ*CMD_W  flattened frontend_command_t per requester
- req_wdata  in  NUM_REQ*DATA_W  flattened write data per requester
- req_ready  out  NUM_REQ  one-hot accept
- command  out  CMD_W  to scheduler
- valid  out  1  command valid to scheduler
- write_data  out  DATA_W  write data to scheduler
- ba_cmd_pm  in  1  scheduler ready
- read_data  in  DATA_W  scheduler read data
- read_data_valid  in  1  scheduler read data valid
- rsp_valid  out  NUM_REQ  one-hot read response valid
- rsp_data  out  DATA_W  read response data (shared by all requesters)
- rd_outstanding  out  $clog2(RD_FIFO_DEPTH)+1  tag FIFO occupancy
- rsp_orphan_err  out  1  sticky: read_data_valid arrived with the tag FIFO empty

Behaviour:
- Reset values: every output is 0, the RR pointer is 0, and the tag FIFO is empty. Reset is asynchronous and aborts any held command; nothing is replayed after reset.
- Slot free = !valid || (valid && ba_cmd_pm).
- Eligible[i] = req_valid[i] && !(op_type of req_cmd[i] == OP_READ && FIFO full).
  - A pop in the same cycle does not relieve full.
  - Writes stay eligible while the FIFO is full.
- Grant: when the slot is free, the first eligible requester at or after the RR pointer (wrapping) wins.
  - req_ready[winner]=1 is driven combinationally in that same cycle.
  - Accept = req_valid && req_ready.
- On accept, at the next posedge:
  - command and write_data are captured (write_data is 0 for reads) and valid=1.
  - The RR pointer moves to winner+1 mod NUM_REQ.
  - For reads only, the winner ID is pushed into the tag FIFO.
- Latency: one cycle from accept to valid.
- While valid && !ba_cmd_pm, command and write_data are held bit-stable and no req_ready is asserted.
- Back-to-back issue: handshake and new accept in the same cycle give zero bubbles.
- Slot free with no eligible requester: valid goes to 0 on the next edge; command keeps its last value.
- Read return, when read_data_valid=1 at a posedge:
  - The head ID is popped.
  - Next cycle: rsp_valid = onehot(ID) and rsp_data = read_data.
  - rsp_valid otherwise goes to 0.
- Read return with the FIFO empty: rsp_orphan_err is set (sticky until reset), rsp_valid stays 0, and nothing is popped.
- Simultaneous push and pop: both take effect and the count is unchanged. FIFO pointers wrap mod RD_FIFO_DEPTH.
- Read responses return strictly in issue order; the scheduler guarantees in-order data.
- States:
  - EMPTY (valid=0): on accept go to HOLD.
  - HOLD (valid=1): on handshake with accept stay in HOLD; on handshake without accept go to EMPTY; without handshake stay in HOLD.

Optional Feature:
- Macro: FRONTEND_ARB_ROW_HIT_PRIO_EN.
- When defined:
  - An eligible requester whose row_addr equals the row_addr of the last issued command beats RR order; among row hits, RR order applies.
  - A hit streak counter increments on each hit grant and resets on a miss grant.
  - When it reaches MAX_HIT_STREAK, the next grant ignores hits (pure RR) and the counter clears.
  - The RR pointer still updates on every grant.
- When undefined: pure round-robin, and no row register or counter exists.

Decomposition:
- frontend_command_t and OP_READ/OP_WRITE come from frontend_command_definition_pkg.
- New package frontend_arb_pkg holds:
  - req_id_t (logic [$clog2(NUM_REQ_MAX)-1:0]) and NUM_REQ_MAX=8.
  - The arb_state_e enum {ARB_EMPTY, ARB_HOLD}.
- Sub-module rd_tag_fifo: synchronous FIFO of req_id_t with push, pop, full, empty and count outputs.

Test Plan:
- Single requester: req0 writes row 5, col 3, data 0x53 with ba_cmd_pm=1 → req_ready[0] in cycle 0, valid with that command in cycle 1, handshake in cycle 1, valid=0 in cycle 2.
- Contention: all 3 requesters hold writes continuously with ba_cmd_pm=1 → grant order 0,1,2,0,1,2 with no bubbles.
- Backpressure: ba_cmd_pm=0 for 5 cycles during HOLD → command and write_data stable, req_ready=0; after release, the next grant goes to the RR successor.
- Tag full: req1 issues 16 reads with no returns → rd_outstanding=16 and req1 reads blocked while req2 writes are still granted; one read_data_valid returns → rsp_valid=3'b010 one cycle later, then req1 is granted.
- Routing and orphan: reads issued in order req2, req0, returns with data 0xA, 0xB → rsp_valid 100 carrying 0xA, then 001 carrying 0xB; an extra read_data_valid → rsp_orphan_err=1 and stays 1.
- Reset mid-HOLD: power_on_rst_n pulsed low with valid=1 → valid=0 and rd_outstanding=0 immediately; the first grant after reset goes to req0.

Source files
------------

// File: rtl/frontend_arb_pkg.sv
// Shared types for the frontend request arbiter: requester IDs, FSM states and
// the wrapping round-robin search used for both normal and row-hit grants.
package frontend_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int ID_W        = $clog2(NUM_REQ_MAX);

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_HOLD  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic    found;
    req_id_t id;
  } rr_pick_t;

  // First set bit of mask at or after ptr, wrapping within n requesters.
  function automatic rr_pick_t rr_pick(input logic [NUM_REQ_MAX-1:0] mask,
                                       input req_id_t ptr, input int n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 0; k < NUM_REQ_MAX; k++) begin
      if (k < n) begin
        idx = int'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!r.found && mask[idx[ID_W-1:0]]) begin
          r.found = 1'b1;
          r.id    = req_id_t'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/frontend_command_definition_pkg.sv
// Frontend command format shared by the loaders, writer and the command scheduler.
// Supplies FRONTEND_CMD_BITS / DQ_BITS defaults when the build does not define them.
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 28
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

package frontend_command_definition_pkg;

  localparam int BANK_W = 3;
  localparam int ROW_W  = 14;
  localparam int COL_W  = 10;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_type_e;

  typedef struct packed {
    op_type_e            op_type;
    logic [BANK_W-1:0]   bank_addr;
    logic [ROW_W-1:0]    row_addr;
    logic [COL_W-1:0]    col_addr;
  } frontend_command_t;

endpackage

// File: rtl/frontend_req_arbiter_rd_tag_fifo.sv
// In-order FIFO of requester IDs for reads in flight; head is the owner of the
// next returning read_data beat.
module rd_tag_fifo
  import frontend_arb_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          power_on_rst_n,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head_id,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  req_id_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/frontend_req_arbiter.sv
// Round-robin arbiter sharing the scheduler's frontend command port, with read
// tag tracking for response routing. Optional row-hit priority: FRONTEND_ARB_ROW_HIT_PRIO_EN.
//
// state     | meaning
// ARB_EMPTY | output slot empty, valid=0
// ARB_HOLD  | command held on the port, valid=1 until ba_cmd_pm
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 28
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

module frontend_req_arbiter
  import frontend_command_definition_pkg::*;
  import frontend_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int CMD_W          = `FRONTEND_CMD_BITS,
  parameter int DATA_W         = `DQ_BITS*8,
  parameter int RD_FIFO_DEPTH  = 16,
  parameter int MAX_HIT_STREAK = 4
) (
  input  logic                              clk,
  input  logic                              power_on_rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]          req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [CMD_W-1:0]                  command,
  output logic                              valid,
  output logic [DATA_W-1:0]                 write_data,
  input  logic                              ba_cmd_pm,
  input  logic [DATA_W-1:0]                 read_data,
  input  logic                              read_data_valid,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_W-1:0]                 rsp_data,
  output logic [$clog2(RD_FIFO_DEPTH):0]    rd_outstanding,
  output logic                              rsp_orphan_err
);

  localparam int OP_LSB = BANK_W + ROW_W + COL_W;

  if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || MAX_HIT_STREAK < 1 ||
      (RD_FIFO_DEPTH & (RD_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("frontend_req_arbiter: unsupported parameterisation");
  end

  arb_state_e          state;
  arb_state_e          state_nxt;
  req_id_t             rr_ptr;
  req_id_t             head_id;
  logic                slot_free;
  logic                grant;
  logic                win_is_read;
  logic [NUM_REQ-1:0]  is_read;
  logic [NUM_REQ-1:0]  eligible;
  logic [CMD_W-1:0]    win_cmd;
  logic [DATA_W-1:0]   win_wdata;
  rr_pick_t            pick_rr;
  rr_pick_t            pick;
  logic                fifo_full;
  logic                fifo_empty;

  assign valid     = (state == ARB_HOLD);
  assign slot_free = !valid || ba_cmd_pm;

  // Full is judged on the registered count, so a same-cycle pop never unblocks a read.
  always_comb begin
    is_read  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      is_read[i]  = (op_type_e'(req_cmd[i*CMD_W + OP_LSB]) == OP_READ);
      eligible[i] = req_valid[i] && !(is_read[i] && fifo_full);
    end
  end

  assign pick_rr = rr_pick(NUM_REQ_MAX'(eligible), rr_ptr, NUM_REQ);

`ifdef FRONTEND_ARB_ROW_HIT_PRIO_EN
  localparam int STREAK_W = $clog2(MAX_HIT_STREAK + 1);

  logic [ROW_W-1:0]     last_row;
  logic                 last_vld;
  logic [STREAK_W-1:0]  hit_streak;
  logic                 streak_capped;
  logic                 hits_allowed;
  logic [NUM_REQ-1:0]   row_hit;
  rr_pick_t             pick_hit;

  assign streak_capped = (hit_streak >= STREAK_W'(MAX_HIT_STREAK));
  assign hits_allowed  = last_vld && !streak_capped;

  always_comb begin
    row_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      row_hit[i] = eligible[i] && hits_allowed &&
                   (req_cmd[i*CMD_W + COL_W +: ROW_W] == last_row);
    end
  end

  assign pick_hit = rr_pick(NUM_REQ_MAX'(row_hit), rr_ptr, NUM_REQ);
  assign pick     = pick_hit.found ? pick_hit : pick_rr;

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      last_row   <= '0;
      last_vld   <= 1'b0;
      hit_streak <= '0;
    end else if (grant) begin
      last_row <= win_cmd[COL_W +: ROW_W];
      last_vld <= 1'b1;
      if (streak_capped)       hit_streak <= '0;
      else if (pick_hit.found) hit_streak <= hit_streak + 1'b1;
      else                     hit_streak <= '0;
    end
  end
`else
  assign pick = pick_rr;
`endif

  assign grant = slot_free && pick.found;

  always_comb begin
    req_ready   = '0;
    win_cmd     = '0;
    win_wdata   = '0;
    win_is_read = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.id == req_id_t'(i)) begin
        req_ready[i] = grant;
        win_cmd      = req_cmd[i*CMD_W +: CMD_W];
        win_wdata    = req_wdata[i*DATA_W +: DATA_W];
        win_is_read  = is_read[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_EMPTY: if (grant) state_nxt = ARB_HOLD;
      ARB_HOLD:  if (ba_cmd_pm && !grant) state_nxt = ARB_EMPTY;
      default:   state_nxt = ARB_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) state <= ARB_EMPTY;
    else                 state <= state_nxt;
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      command    <= '0;
      write_data <= '0;
      rr_ptr     <= '0;
    end else if (grant) begin
      command    <= win_cmd;
      write_data <= win_is_read ? '0 : win_wdata;
      rr_ptr     <= (pick.id == req_id_t'(NUM_REQ - 1)) ? '0 : pick.id + 1'b1;
    end
  end

  rd_tag_fifo #(
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_tag_fifo (
    .clk            (clk),
    .power_on_rst_n (power_on_rst_n),
    .push           (grant && win_is_read),
    .push_id        (pick.id),
    .pop            (read_data_valid),
    .head_id        (head_id),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .count          (rd_outstanding)
  );

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rsp_valid      <= '0;
      rsp_data       <= '0;
      rsp_orphan_err <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (read_data_valid) begin
        if (fifo_empty) begin
          rsp_orphan_err <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] <= (head_id == req_id_t'(i));
          rsp_data <= read_data;
        end
      end
    end
  end

endmodule
